// File: rtl/memory_sequencer.sv
// rtl/memory_sequencer.sv - burst request sequencer driving a 16x8 latch-based memory
//
// Turns client read/write bursts into paced memory pin activity with address
// auto-increment (wrapping at 2**ADDR_W) and captures read data RD_LATENCY
// cycles after each mem_read cycle.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; req_write, req_addr, req_len (beats-1)
//   wr_valid/wr_ready   write beat handshake with wr_data
//   rd_valid, rd_data   read beat strobe and data (no backpressure)
//   done                strobe on the final beat of a burst
//   mem_write, mem_read, mem_activate, mem_addrin, mem_addrout, mem_datain
//                       memory control, address and write data pins
//   mem_dataout         memory read data
module memory_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_activate,
    output logic [ADDR_W-1:0] mem_addrin,
    output logic [ADDR_W-1:0] mem_addrout,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_ISSUE = 2'd2,
        READ_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                wr_ready_q, wr_ready_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_activate_q, mem_activate_d;
    logic [ADDR_W-1:0]   mem_addrin_q, mem_addrin_d;
    logic [ADDR_W-1:0]   mem_addrout_q, mem_addrout_d;
    logic [DATA_W-1:0]   mem_datain_q, mem_datain_d;
    logic                done_wr_q, done_wr_d;
    // Marks that the read issued in the current mem_read cycle is the burst's last.
    logic                rd_last_q, rd_last_d;
    // Beats in flight: stage 0 follows the mem_read cycle, the tail lines up
    // with the cycle in which mem_dataout carries that beat's data.
    logic [RD_LATENCY-1:0] sr_valid_q, sr_valid_d;
    logic [RD_LATENCY-1:0] sr_last_q, sr_last_d;

    logic tail_valid;
    logic tail_last;

    assign tail_valid = sr_valid_q[RD_LATENCY-1];
    assign tail_last  = sr_valid_q[RD_LATENCY-1] & sr_last_q[RD_LATENCY-1];

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        rd_last_d     = 1'b0;
        done_wr_d     = 1'b0;
        mem_addrin_d  = mem_addrin_q;
        mem_addrout_d = mem_addrout_q;
        mem_datain_d  = mem_datain_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = req_len;
                    if (req_write) begin
                        addr_d  = req_addr;
                        state_d = WRITE;
                    end else begin
                        // The first read beat is issued straight from the
                        // request so mem_read rises in the cycle after accept.
                        mem_read_d    = 1'b1;
                        mem_addrout_d = req_addr;
                        rd_last_d     = (req_len == '0);
                        addr_d        = req_addr + 1'b1;
                        state_d       = READ_ISSUE;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    mem_write_d  = 1'b1;
                    mem_addrin_d = addr_q;
                    mem_datain_d = wr_data;
                    addr_d       = addr_q + 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_wr_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            READ_ISSUE: begin
                // cnt_q counts beats still to issue after the one on the pins now.
                if (cnt_q == '0) begin
                    state_d = READ_DRAIN;
                end else begin
                    mem_read_d    = 1'b1;
                    mem_addrout_d = addr_q;
                    rd_last_d     = (cnt_q == LEN_W'(1));
                    addr_d        = addr_q + 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                end
            end
            READ_DRAIN: begin
                if (tail_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_activate_d = mem_write_d | mem_read_d;
        req_ready_d    = (state_d == IDLE);
        wr_ready_d     = (state_d == WRITE);

        sr_valid_d    = '0;
        sr_last_d     = '0;
        sr_valid_d[0] = mem_read_q;
        sr_last_d[0]  = mem_read_q & rd_last_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            sr_valid_d[i] = sr_valid_q[i-1];
            sr_last_d[i]  = sr_last_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            req_ready_q    <= 1'b1;
            wr_ready_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_activate_q <= 1'b0;
            mem_addrin_q   <= '0;
            mem_addrout_q  <= '0;
            mem_datain_q   <= '0;
            done_wr_q      <= 1'b0;
            rd_last_q      <= 1'b0;
            sr_valid_q     <= '0;
            sr_last_q      <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            req_ready_q    <= req_ready_d;
            wr_ready_q     <= wr_ready_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            mem_activate_q <= mem_activate_d;
            mem_addrin_q   <= mem_addrin_d;
            mem_addrout_q  <= mem_addrout_d;
            mem_datain_q   <= mem_datain_d;
            done_wr_q      <= done_wr_d;
            rd_last_q      <= rd_last_d;
            sr_valid_q     <= sr_valid_d;
            sr_last_q      <= sr_last_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign wr_ready     = wr_ready_q;
    assign mem_write    = mem_write_q;
    assign mem_read     = mem_read_q;
    assign mem_activate = mem_activate_q;
    assign mem_addrin   = mem_addrin_q;
    assign mem_addrout  = mem_addrout_q;
    assign mem_datain   = mem_datain_q;
    // Read data passes straight through in the cycle the memory presents it.
    assign rd_valid     = tail_valid;
    assign rd_data      = tail_valid ? mem_dataout : '0;
    assign done         = done_wr_q | tail_last;

endmodule

// File: tb/tb_memory_sequencer.sv
// tb/tb_memory_sequencer.sv - self-checking bench for memory_sequencer
module tb_memory_sequencer;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       last;
        logic [4:0] k;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       preload;
    int         cyc = 0;
    int         n_asserts = 0;
    int         n_fail = 0;

    // DUT with RD_LATENCY=1
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr, req_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, done;
    logic       mem_write, mem_read, mem_activate;
    logic [3:0] mem_addrin, mem_addrout;
    logic [7:0] mem_datain, mem_dataout;

    // DUT with RD_LATENCY=3
    logic       req3_valid, req3_ready, req3_write;
    logic [3:0] req3_addr, req3_len;
    logic       wr3_valid, wr3_ready;
    logic [7:0] wr3_data, rd3_data;
    logic       rd3_valid, done3;
    logic       mem3_write, mem3_read, mem3_activate;
    logic [3:0] mem3_addrin, mem3_addrout;
    logic [7:0] mem3_datain, mem3_dataout;

    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] dout1, p0, p1, p2;
    logic [7:0] ref_mem [16];
    logic [7:0] wdata [16];

    beat_t wr_q[$];
    beat_t rd_q[$];
    beat_t rd3_q[$];
    beat_t wr_e, rd_e, rd3_e;

    int acc1 = 0, acc3 = 0, n_acc = 0;
    int n_mw = 0, n_mr = 0, n_rv = 0, n_done = 0, n_rv3 = 0;
    int first_mw = -1, last_mw = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_sequencer #(.ADDR_W(4), .DATA_W(8), .LEN_W(4), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
        .mem_write(mem_write), .mem_read(mem_read), .mem_activate(mem_activate),
        .mem_addrin(mem_addrin), .mem_addrout(mem_addrout),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    memory_sequencer #(.ADDR_W(4), .DATA_W(8), .LEN_W(4), .RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req3_valid), .req_ready(req3_ready), .req_write(req3_write),
        .req_addr(req3_addr), .req_len(req3_len),
        .wr_valid(wr3_valid), .wr_ready(wr3_ready), .wr_data(wr3_data),
        .rd_valid(rd3_valid), .rd_data(rd3_data), .done(done3),
        .mem_write(mem3_write), .mem_read(mem3_read), .mem_activate(mem3_activate),
        .mem_addrin(mem3_addrin), .mem_addrout(mem3_addrout),
        .mem_datain(mem3_datain), .mem_dataout(mem3_dataout)
    );

    // Memory models: read data appears RD_LATENCY cycles after the mem_read cycle.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 8'(i) ^ 8'h5A;
                mem3[i] <= 8'(i) ^ 8'h5A;
            end
        end else begin
            if (mem_write) mem1[mem_addrin] <= mem_datain;
            if (mem3_write) mem3[mem3_addrin] <= mem3_datain;
        end
        if (mem_read) dout1 <= mem1[mem_addrout];
        if (mem3_read) p0 <= mem3[mem3_addrout];
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_dataout  = dout1;
    assign mem3_dataout = p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop expectations as the DUTs produce beats.
    always @(negedge clk) begin
        if (reset) begin
            if (req_valid && req_ready) begin
                acc1 = cyc + 1;
                n_acc++;
            end
            if (req3_valid && req3_ready) acc3 = cyc + 1;
            if (mem_write || mem_read) begin
                check("activate_eq_or", mem_activate, mem_write | mem_read);
                check("write_read_excl", mem_write & mem_read, 0);
            end
            if (mem_read) n_mr++;
            if (done) begin
                n_done++;
                check("done_has_beat", mem_write | rd_valid, 1);
            end
            if (mem_write) begin
                n_mw++;
                if (first_mw < 0) first_mw = cyc;
                last_mw = cyc;
                check("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    wr_e = wr_q.pop_front();
                    check("mem_addrin", mem_addrin, wr_e.addr);
                    check("mem_datain", mem_datain, wr_e.data);
                    check("wr_done", done, wr_e.last);
                end
            end
            if (rd_valid) begin
                n_rv++;
                check("rd_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    rd_e = rd_q.pop_front();
                    check("rd_data", rd_data, rd_e.data);
                    check("rd_done", done, rd_e.last);
                    check("rd_cycle", cyc, acc1 + rd_e.k + 1);
                end
            end
            if (rd3_valid) begin
                n_rv3++;
                check("rd3_expected", rd3_q.size() != 0, 1);
                if (rd3_q.size() != 0) begin
                    rd3_e = rd3_q.pop_front();
                    check("rd3_data", rd3_data, rd3_e.data);
                    check("rd3_done", done3, rd3_e.last);
                    check("rd3_cycle", cyc, acc3 + rd3_e.k + 3);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_activate", mem_activate, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_mem_addrin", mem_addrin, 0);
        check("rst_mem_addrout", mem_addrout, 0);
        check("rst_mem_datain", mem_datain, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_req3_ready", req3_ready, 1);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] len);
        beat_t e;
        logic [3:0] ak;
        for (int k = 0; k <= int'(len); k++) begin
            ak = a + 4'(k);
            e.addr = ak;
            e.data = ref_mem[ak];
            e.last = (k == int'(len));
            e.k    = 5'(k);
            rd_q.push_back(e);
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] len,
                            input int stall_after, input int stall_n, input bit hold_req);
        beat_t e;
        logic [3:0] ak;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len;
        @(posedge clk); #1;
        if (!hold_req) req_valid = 1'b0;
        check("wr_ready_first", wr_ready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            ak = a + 4'(i);
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            e.addr = ak; e.data = wdata[i]; e.last = (i == int'(len)); e.k = 5'(i);
            wr_q.push_back(e);
            ref_mem[ak] = wdata[i];
            @(posedge clk); #1;
            wr_valid = 1'b0;
            if (i == stall_after) repeat (stall_n) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain(input string tag);
        int budget = 60;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || rd3_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        repeat (3) begin @(posedge clk); #1; end
        check(tag, rd_q.size() + wr_q.size() + rd3_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_mr, s_rv, s_done, s_mw, s_acc;
        beat_t e;
        reset = 1'b0; preload = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wr_valid = 0; wr_data = 0;
        req3_valid = 0; req3_write = 0; req3_addr = 0; req3_len = 0;
        wr3_valid = 0; wr3_data = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check_reset_outputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Full 16-beat read from 0: data addr^0x5A
        s_mr = n_mr; s_rv = n_rv; s_done = n_done;
        do_read(4'h0, 4'hF);
        wait_drain("full_read_drained");
        check("full_read_mem_read_cycles", n_mr - s_mr, 16);
        check("full_read_rd_valid_count", n_rv - s_rv, 16);
        check("full_read_done_count", n_done - s_done, 1);
        check("idle_req_ready", req_ready, 1);

        // Single write
        s_mw = n_mw; s_done = n_done;
        wdata[0] = 8'hA5;
        do_write(4'h3, 4'h0, -1, 0, 1'b0);
        wait_drain("single_write_drained");
        check("single_write_count", n_mw - s_mw, 1);
        check("single_write_done_count", n_done - s_done, 1);

        // Wrapping write burst with a 2-cycle stall after beat 2
        s_mw = n_mw; s_done = n_done; first_mw = -1;
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        do_write(4'hE, 4'h3, 1, 2, 1'b0);
        wait_drain("wrap_write_drained");
        check("wrap_write_count", n_mw - s_mw, 4);
        check("wrap_write_span", last_mw - first_mw, 5);
        check("wrap_write_done_count", n_done - s_done, 1);

        // req_valid held through a busy write, then a back-to-back read of 0x9
        s_acc = n_acc;
        wdata[0] = 8'hC3; wdata[1] = 8'h3C;
        do_write(4'h9, 4'h1, 0, 2, 1'b1);
        e.addr = 4'h9; e.data = ref_mem[9]; e.last = 1'b1; e.k = 5'd0;
        rd_q.push_back(e);
        req_write = 1'b0; req_addr = 4'h9; req_len = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_drain("coherence_drained");
        check("accept_count_busy", n_acc - s_acc, 2);

        // Reset in the middle of a read burst
        do_read(4'h0, 4'hF);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        rd_q.delete();
        s_rv = n_rv; s_done = n_done;
        @(posedge clk); #3;
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("abort_no_rd_valid", n_rv - s_rv, 0);
        check("abort_no_done", n_done - s_done, 0);

        // First request after reset, wrapping read F,0
        s_rv = n_rv; s_done = n_done;
        do_read(4'hF, 4'h1);
        wait_drain("post_reset_read_drained");
        check("post_reset_rd_count", n_rv - s_rv, 2);
        check("post_reset_done_count", n_done - s_done, 1);

        // RD_LATENCY=3 instance
        e.addr = 4'h7; e.data = 8'h07 ^ 8'h5A; e.last = 1'b0; e.k = 5'd0;
        rd3_q.push_back(e);
        e.addr = 4'h8; e.data = 8'h08 ^ 8'h5A; e.last = 1'b1; e.k = 5'd1;
        rd3_q.push_back(e);
        req3_valid = 1'b1; req3_write = 1'b0; req3_addr = 4'h7; req3_len = 4'h1;
        @(posedge clk); #1;
        req3_valid = 1'b0;
        wait_drain("lat3_drained");
        check("lat3_rd_count", n_rv3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
